// File: rtl/scm_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : scm_port_arbiter
// Purpose  : Two-master round-robin front end for a 1W/1R standard-cell memory,
//            with optional zero-fill of the array after reset.
// Revision : 1.0 - initial release
// ============================================================================
module scm_port_arbiter #(
  parameter int AW             = 4,
  parameter int DW             = 16,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          M0_REQ,
  input  logic          M0_WR,
  input  logic [AW-1:0] M0_ADDR,
  input  logic [DW-1:0] M0_WDATA,
  output logic          M0_GNT,
  output logic          M0_RVALID,
  input  logic          M1_REQ,
  input  logic          M1_WR,
  input  logic [AW-1:0] M1_ADDR,
  input  logic [DW-1:0] M1_WDATA,
  output logic          M1_GNT,
  output logic          M1_RVALID,
  output logic [DW-1:0] RDATA,
  output logic          INIT_DONE,
  output logic          SCM_WE,
  output logic [AW-1:0] SCM_WADDR,
  output logic [DW-1:0] SCM_DIN,
  output logic          SCM_RE,
  output logic [AW-1:0] SCM_RADDR,
  input  logic [DW-1:0] SCM_DOUT
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int            c_depth     = 2 ** AW;
  localparam logic [AW-1:0] c_last_addr = AW'(c_depth - 1);
  localparam state_t        c_rst_state = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

  state_t        r_state;
  state_t        w_next_state;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_next_cnt;
  logic          r_wr_last;
  logic          r_rd_last;
  logic          r_rv0;
  logic          r_rv1;

  logic          w_wc0, w_wc1, w_rc0, w_rc1;
  logic          w_wsel, w_rsel;
  logic          w_wgnt, w_rgnt;
  logic [AW-1:0] w_waddr, w_raddr;
  logic [DW-1:0] w_wdata;

  assign w_wc0 = M0_REQ & M0_WR;
  assign w_wc1 = M1_REQ & M1_WR;
  assign w_rc0 = M0_REQ & ~M0_WR;
  assign w_rc1 = M1_REQ & ~M1_WR;

  // Under contention the master that did not win last time gets the port.
  assign w_wsel  = (w_wc0 && w_wc1) ? ~r_wr_last : w_wc1;
  assign w_rsel  = (w_rc0 && w_rc1) ? ~r_rd_last : w_rc1;
  assign w_waddr = w_wsel ? M1_ADDR  : M0_ADDR;
  assign w_wdata = w_wsel ? M1_WDATA : M0_WDATA;
  assign w_raddr = w_rsel ? M1_ADDR  : M0_ADDR;

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_wgnt       = 1'b0;
    w_rgnt       = 1'b0;
    SCM_WE       = 1'b0;
    SCM_WADDR    = '0;
    SCM_DIN      = '0;
    SCM_RE       = 1'b0;
    SCM_RADDR    = '0;
    M0_GNT       = 1'b0;
    M1_GNT       = 1'b0;

    case (r_state)
      ST_INIT: begin
        // RSTN gating keeps the write strobe low while reset is held.
        SCM_WE     = RSTN;
        SCM_WADDR  = r_cnt;
        w_next_cnt = r_cnt + 1'b1;
        if (r_cnt == c_last_addr) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        w_wgnt = RSTN & (w_wc0 | w_wc1);
        // A read colliding with this cycle's write waits one cycle for the new data.
        w_rgnt = RSTN & (w_rc0 | w_rc1) & ~(w_wgnt && (w_raddr == w_waddr));
        if (w_wgnt) begin
          SCM_WE    = 1'b1;
          SCM_WADDR = w_waddr;
          SCM_DIN   = w_wdata;
        end
        if (w_rgnt) begin
          SCM_RE    = 1'b1;
          SCM_RADDR = w_raddr;
        end
        M0_GNT = (w_wgnt & ~w_wsel) | (w_rgnt & ~w_rsel);
        M1_GNT = (w_wgnt &  w_wsel) | (w_rgnt &  w_rsel);
      end
      default: begin
        w_next_state = c_rst_state;
        w_next_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state   <= c_rst_state;
      r_cnt     <= '0;
      r_wr_last <= 1'b1;
      r_rd_last <= 1'b1;
      r_rv0     <= 1'b0;
      r_rv1     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      if (w_wgnt) r_wr_last <= w_wsel;
      if (w_rgnt) r_rd_last <= w_rsel;
      r_rv0 <= w_rgnt & ~w_rsel;
      r_rv1 <= w_rgnt &  w_rsel;
    end
  end

  assign M0_RVALID = r_rv0;
  assign M1_RVALID = r_rv1;
  assign RDATA     = (r_rv0 | r_rv1) ? SCM_DOUT : '0;
  assign INIT_DONE = (r_state == ST_RUN);

endmodule
`default_nettype wire

// File: doc/scm_port_arbiter.md
Name: scm_port_arbiter

Overview:
- Two-master front end for one standard-cell memory macro with one write port and one read port (default 16 words x 16 bits).
- Arbitrates write requests and read requests independently, each with round-robin priority.
- Sequences the macro's WE/RE/address/data pins and returns read data to the requesting master with a valid strobe.
- Optionally clears the whole array after reset through an init state machine.

Parameters:
- AW, 4, address width; DEPTH = 2**AW.
- DW, 16, data width.
- CLEAR_ON_RESET, 1, 1 = zero-fill all words after reset before accepting requests; 0 = go directly to RUN.

Ports:
- CLK  in  1  clock, shared with the memory macro.
- RSTN  in  1  reset.
- M0_REQ  in  1  master 0 request.
- M0_WR  in  1  master 0 type: 1 = write, 0 = read.
- M0_ADDR  in  AW  master 0 address.
- M0_WDATA  in  DW  master 0 write data.
- M0_GNT  out  1  master 0 request accepted this cycle.
- M0_RVALID  out  1  read data on RDATA is for master 0.
- M1_REQ, M1_WR, M1_ADDR, M1_WDATA, M1_GNT, M1_RVALID: same as master 0, for master 1.
- RDATA  out  DW  read return data, shared by both masters.
- INIT_DONE  out  1  array cleared; controller is in RUN.
- SCM_WE  out  1  macro write enable.
- SCM_WADDR  out  AW  macro write address.
- SCM_DIN  out  DW  macro write data.
- SCM_RE  out  1  macro read enable.
- SCM_RADDR  out  AW  macro read address.
- SCM_DOUT  in  DW  macro read data, valid the cycle after SCM_RE.

Behaviour:
- One clock, CLK. RSTN is asynchronous, active-low.
- While RSTN=0: FSM=INIT (or RUN if CLEAR_ON_RESET=0); init counter=0; wr_last=rd_last=1 (master 0 wins first contention).
- While RSTN=0, these outputs are 0: M*_GNT, M*_RVALID, RDATA, SCM_WE, SCM_RE, SCM_*ADDR, SCM_DIN. INIT_DONE=0, or 1 when CLEAR_ON_RESET=0.
- INIT state:
  - SCM_WE=1, SCM_WADDR=counter, SCM_DIN=0; counter increments every cycle.
  - SCM_RE=0 and both GNTs=0; requests are held off, not dropped.
  - When counter reaches DEPTH-1: go to RUN, INIT_DONE becomes 1 on the next edge. INIT lasts exactly DEPTH cycles.
- RUN state, write arbitration (combinational, same cycle):
  - Write candidates are masters with REQ=1 and WR=1.
  - One candidate: it is granted.
  - Two candidates: the master that is not wr_last is granted; wr_last updates to the granted master.
  - On grant: SCM_WE=1, SCM_WADDR and SCM_DIN come from the granted master.
- RUN state, read arbitration: same rules with rd_last. On grant: SCM_RE=1, SCM_RADDR from the granted master.
- One read and one write can be granted in the same cycle, to different masters.
- Read/write hazard:
  - If the granted read address equals the granted write address in the same cycle, the read is not granted: SCM_RE=0, rd_last unchanged.
  - The master keeps its request and is granted next cycle, so it returns the newly written data.
- GNT semantics: combinational. GNT=1 means the request is consumed at this edge. GNT=0 means the master must hold REQ, WR, ADDR and WDATA stable.
- Read return, latency 1:
  - A registered owner flag records which master's read was granted.
  - Next cycle: that master's RVALID=1 and RDATA=SCM_DOUT. RDATA=0 when neither RVALID is set.
  - Back-to-back reads stream: one RVALID per cycle.
- Unused SCM address and data outputs are driven 0 when their enable is 0.
- RSTN asserted mid-INIT or mid-read: the in-flight RVALID is dropped, all outputs go to reset values immediately, and INIT restarts from address 0 after release.
- Address wrap is not applicable: all addresses are in range because DEPTH = 2**AW.

Test Plan:
- CLEAR_ON_RESET=1, release RSTN -> 16 cycles of SCM_WE=1 with SCM_WADDR 0..15 and SCM_DIN=0; GNT=0 throughout; INIT_DONE=1 on cycle 16. Then M0 reads addr 5 -> M0_RVALID next cycle, RDATA=0x0000.
- M0 writes addr 3 = 0xA5A5; next cycle M1 reads addr 3 -> M1_GNT=1, and one cycle later M1_RVALID=1 with RDATA=0xA5A5 (bench memory model returns the written data).
- After reset, both masters request writes (addr 1 and addr 2) continuously for 4 cycles -> grants go M0, M1, M0, M1; the losing master holds its request each cycle.
- Same cycle: M0 writes addr 7 = 0x1234 and M1 reads addr 7 -> M0_GNT=1, M1_GNT=0; next cycle M1_GNT=1; the cycle after, M1_RVALID=1 with RDATA=0x1234.
- Same cycle: M0 reads addr 2 and M1 writes addr 9 = 0xBEEF -> both GNT=1, SCM_RE=1 and SCM_WE=1 together; M0_RVALID follows next cycle.
- RSTN pulsed low when init counter = 8 -> all outputs 0 asynchronously; after release, INIT restarts at SCM_WADDR=0 and completes 16 cycles later.
